// File: rtl/ddma_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddma_mem_arbiter
// Description : Round-robin arbiter sharing the single memory port of the
//               double DMA between the receive engine (writes) and the send
//               engine (reads). The port is granted in tenures that end on a
//               last beat or when the owner drops its request.
// Revision    : 1.0 - initial release
//
// Optional feature macro: DDMA_ARB_BURST_LIMIT_EN
//   When defined, a tenure is force-ended after MAX_BURST beats whenever the
//   other engine is waiting. When undefined there is no beat counter and
//   MAX_BURST is ignored.
//
// Ports:
//   clock_i        clock, all logic on rising edge
//   reset_i        synchronous active-low reset
//   rx_req_i       receive engine requests the port
//   rx_last_i      current rx beat is the last of its transfer
//   rx_addr_i      rx beat address
//   rx_wdata_i     rx write data
//   rx_gnt_o       rx owns the port
//   tx_req_i       send engine requests the port
//   tx_last_i      current tx beat is the last of its transfer
//   tx_addr_i      tx beat address
//   tx_gnt_o       tx owns the port
//   tx_rdata_o     read data returned to tx (0 when not valid)
//   tx_rvalid_o    tx_rdata_o valid
//   mem_enable_o   memory access this cycle
//   mem_wr_o       1 = write, 0 = read
//   mem_addr_o     memory address
//   mem_wdata_o    memory write data
//   mem_rdata_i    memory read data, one-cycle latency
//   busy_o         a tenure is active
// ============================================================================
module ddma_mem_arbiter #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH       = 16,
  parameter int MAX_BURST        = 16
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        rx_req_i,
  input  logic                        rx_last_i,
  input  logic [ADDR_WIDTH-1:0]       rx_addr_i,
  input  logic [MEMORY_BUS_WIDTH-1:0] rx_wdata_i,
  output logic                        rx_gnt_o,
  input  logic                        tx_req_i,
  input  logic                        tx_last_i,
  input  logic [ADDR_WIDTH-1:0]       tx_addr_i,
  output logic                        tx_gnt_o,
  output logic [MEMORY_BUS_WIDTH-1:0] tx_rdata_o,
  output logic                        tx_rvalid_o,
  output logic                        mem_enable_o,
  output logic                        mem_wr_o,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_wdata_o,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_rdata_i,
  output logic                        busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_RX = 2'd1,
    OWN_TX = 2'd2
  } state_e;

  localparam logic SERVED_RX = 1'b0;
  localparam logic SERVED_TX = 1'b1;

  state_e state_q, state_d;
  logic   last_served_q, last_served_d;
  logic   tx_rvalid_q;

  logic rx_gnt, tx_gnt, owned;
  logic own_req, other_req, own_last;
  logic beat, tx_beat;
  logic cap_hit, tenure_end, tenure_start;

  assign rx_gnt    = (state_q == OWN_RX);
  assign tx_gnt    = (state_q == OWN_TX);
  assign owned     = rx_gnt | tx_gnt;
  assign own_req   = (rx_gnt & rx_req_i) | (tx_gnt & tx_req_i);
  assign other_req = (rx_gnt & tx_req_i) | (tx_gnt & rx_req_i);
  assign own_last  = (rx_gnt & rx_last_i) | (tx_gnt & tx_last_i);
  assign beat      = own_req;
  assign tx_beat   = tx_gnt & tx_req_i;

  // A tenure ends on a last beat, when the owner lets go, or at the cap.
  assign tenure_end = (owned & ~own_req) | (beat & own_last) | cap_hit;

`ifdef DDMA_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // The beat that brings the count to MAX_BURST (or any beat once saturated)
  // hands the port over if the other engine is waiting.
  assign cap_hit = beat & other_req & (beat_cnt_q >= CNT_LAST);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (tenure_start) begin
      beat_cnt_d = '0;
    end else if (beat && (beat_cnt_q != CNT_MAX)) begin
      beat_cnt_d = beat_cnt_q + CNT_ONE;
    end
  end
`else
  logic unused_cfg_w;

  assign cap_hit      = 1'b0;
  assign unused_cfg_w = tenure_start ^ (MAX_BURST < 1);
`endif

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    tenure_start  = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the engine not served last wins.
        if (rx_req_i && (!tx_req_i || (last_served_q == SERVED_TX))) begin
          state_d       = OWN_RX;
          last_served_d = SERVED_RX;
          tenure_start  = 1'b1;
        end else if (tx_req_i) begin
          state_d       = OWN_TX;
          last_served_d = SERVED_TX;
          tenure_start  = 1'b1;
        end
      end
      OWN_RX, OWN_TX: begin
        if (tenure_end) begin
          if (other_req) begin
            // Direct handover, no idle cycle in between.
            state_d       = rx_gnt ? OWN_TX : OWN_RX;
            last_served_d = rx_gnt ? SERVED_TX : SERVED_RX;
            tenure_start  = 1'b1;
          end else if (own_req) begin
            // Owner keeps requesting: fresh tenure for the same engine.
            tenure_start  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      last_served_q <= SERVED_TX;
      tx_rvalid_q   <= 1'b0;
`ifdef DDMA_ARB_BURST_LIMIT_EN
      beat_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      tx_rvalid_q   <= tx_beat;
`ifdef DDMA_ARB_BURST_LIMIT_EN
      beat_cnt_q    <= beat_cnt_d;
`endif
    end
  end

  assign rx_gnt_o     = rx_gnt;
  assign tx_gnt_o     = tx_gnt;
  assign busy_o       = owned;
  assign mem_enable_o = beat;
  assign mem_wr_o     = rx_gnt;
  assign mem_addr_o   = rx_gnt ? rx_addr_i : (tx_gnt ? tx_addr_i : '0);
  assign mem_wdata_o  = rx_gnt ? rx_wdata_i : '0;
  // Read data is passed through only in the cycle its beat's result returns,
  // regardless of who owns the port by then.
  assign tx_rvalid_o  = tx_rvalid_q;
  assign tx_rdata_o   = tx_rvalid_q ? mem_rdata_i : '0;

endmodule
`default_nettype wire
